// File: rtl/c432_sched_pkg.sv
// Shared definitions for the c432 interrupt scheduler.
//   NCH_DEF        : default number of channels per request bus
//   BUS_A/B/C      : encodings of the granted bus (A has the highest priority)
//   state_e        : scheduler FSM states
//   grant_t        : registered grant (bus + channel)
package c432_sched_pkg;

    localparam int NCH_DEF = 9;

    localparam logic [1:0] BUS_A = 2'd0;
    localparam logic [1:0] BUS_B = 2'd1;
    localparam logic [1:0] BUS_C = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARB   = 2'd1,
        GRANT = 2'd2
    } state_e;

    typedef struct packed {
        logic [1:0] bus;
        logic [3:0] chan;
    } grant_t;

endpackage

// File: rtl/c432_prio_sel.sv
// Combinational fixed-priority selector over three masked pending vectors.
// Bus A beats bus B beats bus C; within a bus the lowest index wins.
//   ma, mb, mc : masked pending vectors for buses A, B, C
//   found      : at least one bit is set
//   bus        : winning bus (BUS_A/BUS_B/BUS_C), BUS_A when nothing is found
//   chan       : winning channel index, 0 when nothing is found
module c432_prio_sel
    import c432_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF
) (
    input  logic [NCH-1:0] ma,
    input  logic [NCH-1:0] mb,
    input  logic [NCH-1:0] mc,
    output logic           found,
    output logic [1:0]     bus,
    output logic [3:0]     chan
);

    // Scan from the lowest-priority bus and highest index upward so that
    // each later hit overwrites an earlier, lower-priority one.
    always_comb begin
        found = 1'b0;
        bus   = BUS_A;
        chan  = 4'd0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mc[i]) begin
                found = 1'b1;
                bus   = BUS_C;
                chan  = 4'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mb[i]) begin
                found = 1'b1;
                bus   = BUS_B;
                chan  = 4'(i);
            end
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            if (ma[i]) begin
                found = 1'b1;
                bus   = BUS_A;
                chan  = 4'(i);
            end
        end
    end

endmodule

// File: rtl/c432_irq_sched.sv
// Sequential interrupt scheduler around the c432 three-bus priority function.
// Requests are latched into sticky per-bus pending registers, masked by a
// per-channel enable, and granted one at a time through a valid/ack handshake.
// A grant retires on ack or after TIMEOUT cycles without ack.
//   CK, RST     : clock, synchronous active-high reset
//   req_a/b/c   : request lines per bus (A highest priority)
//   en_we       : enable-mask write strobe, en_wdata the new mask
//   irq_ack     : consumer acknowledge while irq_valid is high
//   irq_valid   : grant valid, irq_bus/irq_chan the granted source
//   timeout_err : one-cycle pulse after a grant is abandoned
//   pend_any    : some unmasked pending bit is set (combinational)
//   en_q        : current enable mask
module c432_irq_sched
    import c432_sched_pkg::*;
#(
    parameter int NCH     = NCH_DEF,
    parameter int TIMEOUT = 15
) (
    input  logic           CK,
    input  logic           RST,
    input  logic [NCH-1:0] req_a,
    input  logic [NCH-1:0] req_b,
    input  logic [NCH-1:0] req_c,
    input  logic           en_we,
    input  logic [NCH-1:0] en_wdata,
    input  logic           irq_ack,
    output logic           irq_valid,
    output logic [1:0]     irq_bus,
    output logic [3:0]     irq_chan,
    output logic           timeout_err,
    output logic           pend_any,
    output logic [NCH-1:0] en_q
);

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    state_e         state;
    grant_t         gnt_q;
    logic [TW-1:0]  tcnt;

    logic [NCH-1:0] pend_a, pend_b, pend_c;
    logic [NCH-1:0] m_a, m_b, m_c;
    logic [NCH-1:0] clr_a, clr_b, clr_c;
    logic [NCH-1:0] gnt_dec;

    logic           sel_found;
    logic [1:0]     sel_bus;
    logic [3:0]     sel_chan;

    logic           expire;
    logic           retire;

    assign m_a      = pend_a & en_q;
    assign m_b      = pend_b & en_q;
    assign m_c      = pend_c & en_q;
    assign pend_any = |(m_a | m_b | m_c);

    assign irq_bus  = gnt_q.bus;
    assign irq_chan = gnt_q.chan;

    c432_prio_sel #(
        .NCH (NCH)
    ) u_sel (
        .ma    (m_a),
        .mb    (m_b),
        .mc    (m_c),
        .found (sel_found),
        .bus   (sel_bus),
        .chan  (sel_chan)
    );

    // Retire decision and one-hot clear of the granted pending bit.
    always_comb begin
        expire = 1'b0;
        if (TIMEOUT != 0) begin
            expire = (state == GRANT) && !irq_ack && (tcnt == TW'(TIMEOUT - 1));
        end
        retire  = (state == GRANT) && (irq_ack || expire);
        gnt_dec = {{(NCH - 1){1'b0}}, 1'b1} << gnt_q.chan;
        clr_a   = '0;
        clr_b   = '0;
        clr_c   = '0;
        if (retire) begin
            case (gnt_q.bus)
                BUS_A:   clr_a = gnt_dec;
                BUS_B:   clr_b = gnt_dec;
                BUS_C:   clr_c = gnt_dec;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (RST) begin
            state       <= IDLE;
            pend_a      <= '0;
            pend_b      <= '0;
            pend_c      <= '0;
            en_q        <= '1;
            irq_valid   <= 1'b0;
            gnt_q       <= '0;
            timeout_err <= 1'b0;
            tcnt        <= '0;
        end else begin
            // A new request on a bit being cleared wins, so it is re-granted.
            pend_a      <= (pend_a & ~clr_a) | req_a;
            pend_b      <= (pend_b & ~clr_b) | req_b;
            pend_c      <= (pend_c & ~clr_c) | req_c;
            if (en_we) begin
                en_q <= en_wdata;
            end
            timeout_err <= 1'b0;

            case (state)
                IDLE: begin
                    if (pend_any) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    // The mask may have changed since IDLE; give up quietly.
                    if (sel_found) begin
                        gnt_q.bus  <= sel_bus;
                        gnt_q.chan <= sel_chan;
                        irq_valid  <= 1'b1;
                        tcnt       <= '0;
                        state      <= GRANT;
                    end else begin
                        state <= IDLE;
                    end
                end
                GRANT: begin
                    if (retire) begin
                        irq_valid   <= 1'b0;
                        timeout_err <= expire;
                        state       <= IDLE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                default: begin
                    irq_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_c432_irq_sched.sv
module tb_c432_irq_sched;

    logic       CK;
    logic       RST;
    logic [8:0] req_a, req_b, req_c;
    logic       en_we;
    logic [8:0] en_wdata;
    logic       irq_ack;
    logic       irq_valid;
    logic [1:0] irq_bus;
    logic [3:0] irq_chan;
    logic       timeout_err;
    logic       pend_any;
    logic [8:0] en_q;

    int total = 0;
    int bad   = 0;

    c432_irq_sched #(
        .NCH     (9),
        .TIMEOUT (15)
    ) dut (
        .CK          (CK),
        .RST         (RST),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_c       (req_c),
        .en_we       (en_we),
        .en_wdata    (en_wdata),
        .irq_ack     (irq_ack),
        .irq_valid   (irq_valid),
        .irq_bus     (irq_bus),
        .irq_chan    (irq_chan),
        .timeout_err (timeout_err),
        .pend_any    (pend_any),
        .en_q        (en_q)
    );

    initial CK = 1'b0;
    always #5 CK = ~CK;

    // Advance one clock; inputs driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge CK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RST      = 1'b1;
        req_a    = '0;
        req_b    = '0;
        req_c    = '0;
        en_we    = 1'b0;
        en_wdata = '0;
        irq_ack  = 1'b0;
        step();
        step();
        RST = 1'b0;

        // Reset state
        chk("rst_valid", 32'(irq_valid), 32'd0);
        chk("rst_bus", 32'(irq_bus), 32'd0);
        chk("rst_chan", 32'(irq_chan), 32'd0);
        chk("rst_terr", 32'(timeout_err), 32'd0);
        chk("rst_pend_any", 32'(pend_any), 32'd0);
        chk("rst_en_q", 32'(en_q), 32'h1FF);

        // Single request on bus B chan 4, immediate ack
        step(); req_b = 9'h010;
        step(); req_b = '0;
        chk("t1_c1_valid", 32'(irq_valid), 32'd0);
        step();
        chk("t1_arb_valid", 32'(irq_valid), 32'd0);
        step();
        chk("t1_valid", 32'(irq_valid), 32'd1);
        chk("t1_bus", 32'(irq_bus), 32'd1);
        chk("t1_chan", 32'(irq_chan), 32'd4);
        irq_ack = 1'b1;
        step(); irq_ack = 1'b0;
        chk("t1_after_valid", 32'(irq_valid), 32'd0);
        chk("t1_after_pend", 32'(pend_any), 32'd0);

        // Bus A chan 8 beats bus C chan 0; second grant 3 cycles later
        step(); req_a = 9'h100; req_c = 9'h001;
        step();
        step(); req_a = '0; req_c = '0;
        step();
        chk("t2_g1_valid", 32'(irq_valid), 32'd1);
        chk("t2_g1_bus", 32'(irq_bus), 32'd0);
        chk("t2_g1_chan", 32'(irq_chan), 32'd8);
        irq_ack = 1'b1;
        step(); irq_ack = 1'b0;
        chk("t2_idle_valid", 32'(irq_valid), 32'd0);
        chk("t2_idle_pend", 32'(pend_any), 32'd1);
        step();
        chk("t2_arb_valid", 32'(irq_valid), 32'd0);
        step();
        chk("t2_g2_valid", 32'(irq_valid), 32'd1);
        chk("t2_g2_bus", 32'(irq_bus), 32'd2);
        chk("t2_g2_chan", 32'(irq_chan), 32'd0);
        irq_ack = 1'b1;
        step(); irq_ack = 1'b0;
        chk("t2_end_valid", 32'(irq_valid), 32'd0);
        chk("t2_end_pend", 32'(pend_any), 32'd0);

        // Masked channel stays pending without a grant, unmasking grants it
        step(); en_we = 1'b1; en_wdata = 9'h1FB;
        step(); en_we = 1'b0; req_a = 9'h004;
        chk("t3_en_q", 32'(en_q), 32'h1FB);
        step(); req_a = '0;
        chk("t3_masked_pend", 32'(pend_any), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_masked_valid", 32'(irq_valid), 32'd0);
            chk("t3_masked_pend2", 32'(pend_any), 32'd0);
        end
        en_we = 1'b1; en_wdata = 9'h1FF;
        step(); en_we = 1'b0;
        chk("t3_unmask_pend", 32'(pend_any), 32'd1);
        step();
        chk("t3_arb_valid", 32'(irq_valid), 32'd0);
        step();
        chk("t3_valid", 32'(irq_valid), 32'd1);
        chk("t3_bus", 32'(irq_bus), 32'd0);
        chk("t3_chan", 32'(irq_chan), 32'd2);
        irq_ack = 1'b1;
        step(); irq_ack = 1'b0;
        chk("t3_end_valid", 32'(irq_valid), 32'd0);

        // Timeout: 15 grant cycles, then a one-cycle error pulse
        step(); req_a = 9'h002;
        step(); req_a = '0;
        step();
        for (int k = 0; k < 15; k++) begin
            step();
            chk("t4_hold_valid", 32'(irq_valid), 32'd1);
            chk("t4_hold_chan", 32'(irq_chan), 32'd1);
            chk("t4_hold_terr", 32'(timeout_err), 32'd0);
        end
        step();
        chk("t4_exp_valid", 32'(irq_valid), 32'd0);
        chk("t4_exp_terr", 32'(timeout_err), 32'd1);
        chk("t4_exp_pend", 32'(pend_any), 32'd0);
        step();
        chk("t4_terr_pulse", 32'(timeout_err), 32'd0);

        // Ack in the last allowed cycle wins over the timeout
        step(); req_a = 9'h002;
        step(); req_a = '0;
        step();
        for (int k = 0; k < 15; k++) begin
            step();
            chk("t4b_hold_valid", 32'(irq_valid), 32'd1);
            if (k == 14) irq_ack = 1'b1;
        end
        step(); irq_ack = 1'b0;
        chk("t4b_valid", 32'(irq_valid), 32'd0);
        chk("t4b_terr", 32'(timeout_err), 32'd0);
        chk("t4b_pend", 32'(pend_any), 32'd0);
        step();
        chk("t4b_terr2", 32'(timeout_err), 32'd0);

        // Ack and new request on the same bit: set wins, re-granted
        step(); req_a = 9'h008;
        step(); req_a = '0;
        step();
        step();
        chk("t5_g1_valid", 32'(irq_valid), 32'd1);
        chk("t5_g1_chan", 32'(irq_chan), 32'd3);
        irq_ack = 1'b1; req_a = 9'h008;
        step(); irq_ack = 1'b0; req_a = '0;
        chk("t5_idle_valid", 32'(irq_valid), 32'd0);
        chk("t5_idle_pend", 32'(pend_any), 32'd1);
        step();
        chk("t5_arb_valid", 32'(irq_valid), 32'd0);
        step();
        chk("t5_g2_valid", 32'(irq_valid), 32'd1);
        chk("t5_g2_bus", 32'(irq_bus), 32'd0);
        chk("t5_g2_chan", 32'(irq_chan), 32'd3);
        irq_ack = 1'b1;
        step(); irq_ack = 1'b0;
        chk("t5_end_pend", 32'(pend_any), 32'd0);

        // Reset in the middle of a grant
        step(); en_we = 1'b1; en_wdata = 9'h0FF;
        step(); en_we = 1'b0; req_a = 9'h001; req_b = 9'h002;
        step(); req_a = '0; req_b = '0;
        step();
        step();
        chk("t6_valid", 32'(irq_valid), 32'd1);
        chk("t6_chan", 32'(irq_chan), 32'd0);
        step(); RST = 1'b1;
        step(); RST = 1'b0;
        chk("t6_rst_valid", 32'(irq_valid), 32'd0);
        chk("t6_rst_en_q", 32'(en_q), 32'h1FF);
        chk("t6_rst_pend", 32'(pend_any), 32'd0);
        chk("t6_rst_terr", 32'(timeout_err), 32'd0);
        chk("t6_rst_bus", 32'(irq_bus), 32'd0);
        step();
        chk("t6_post_terr", 32'(timeout_err), 32'd0);
        chk("t6_post_valid", 32'(irq_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/c432_irq_sched.md
# c432_irq_sched

Sequential interrupt scheduler built around the c432 three-bus, nine-channel priority function. It latches requests from buses A, B and C into sticky pending registers and applies a per-channel enable mask. It grants one channel at a time through a valid/ack handshake and retires the granted request on acknowledge or timeout. It sits between the peripheral request lines and the CPU interrupt port, replacing direct use of the combinational c432 decode.

## Interface
Parameters:
- NCH, 9, channels per bus; channel 0 has the highest priority.
- TIMEOUT, 15, maximum cycles `irq_valid` stays high without ack; 0 disables the timeout.

Ports:
- CK  in  1  clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset.
- req_a  in  NCH  bus A request lines (highest-priority bus); sampled every cycle.
- req_b  in  NCH  bus B request lines.
- req_c  in  NCH  bus C request lines (lowest-priority bus).
- en_we  in  1  write strobe for the enable mask.
- en_wdata  in  NCH  new enable mask value.
- irq_ack  in  1  acknowledge from the consumer; only meaningful while `irq_valid` = 1.
- irq_valid  out  1  grant valid.
- irq_bus  out  2  granted bus: 0 = A, 1 = B, 2 = C.
- irq_chan  out  4  granted channel, 0..NCH-1.
- timeout_err  out  1  one-cycle pulse when a grant is abandoned.
- pend_any  out  1  at least one unmasked pending bit is set.
- en_q  out  NCH  current enable mask.

## Operation
- **Pending registers.** Three NCH-bit sticky registers, one per bus: `pend_x <= (pend_x & ~clr_x) | req_x`.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- **Masking.** A channel is eligible on a bus when `pend_x[i] & en_q[i]`.
  - Masking does not clear pending bits.
  - `en_we` updates `en_q` on the next edge.
- **Priority.** Any eligible bit on A beats B, and any eligible bit on B beats C. Within a bus, the lowest index wins.
- **FSM states.** IDLE, ARB, GRANT.
  - IDLE: if `pend_any`, go to ARB; otherwise stay.
  - ARB: register the winner into `irq_bus`/`irq_chan` and go to GRANT.
    - If nothing is eligible any more (the mask changed), return to IDLE with no grant.
  - GRANT: `irq_valid` = 1, and `irq_bus`/`irq_chan` are held stable.
    - `irq_ack` = 1: clear the winner's pending bit and go to IDLE.
    - TIMEOUT cycles elapse without ack: clear the winner's pending bit, pulse `timeout_err`, and go to IDLE.
- **Grant lifetime.** A grant is never revoked by new higher-priority requests or by mask writes during GRANT. Preemption takes effect at the next ARB.
- **Reset values.** RST in any state returns the FSM to IDLE and sets:
  - all pending bits = 0
  - `en_q` = all ones
  - `irq_valid` = 0, `irq_bus` = 0, `irq_chan` = 0
  - `timeout_err` = 0
  - timeout counter = 0
  - RST mid-grant drops the grant with no `timeout_err`.

## Timing
- **Request to grant.** Request high in cycle 0 → pending set in cycle 1 (IDLE sees it) → ARB in cycle 2 → `irq_valid` high in cycle 3.
- **Ack.** Ack is sampled on the edge closing a GRANT cycle. `irq_valid` = 0 in the following cycle (IDLE), and the pending bit reads cleared that same cycle.
- **Minimum grant period.** 3 cycles per grant with immediate ack (IDLE, ARB, GRANT).
- **Timeout counter.** Cleared on entry to GRANT and incremented each GRANT cycle without ack.
  - If the count reaches TIMEOUT-1 and there is still no ack, the FSM exits. `timeout_err` = 1 for exactly one cycle, in the following IDLE cycle.
  - An ack in the last allowed cycle wins; no error is raised.
- **Output timing.** All outputs are registered except `pend_any`, which is combinational from the registers.

## Structure
- **Shared package `c432_sched_pkg`:**
  - constants NCH_DEF = 9 and BUS_A/BUS_B/BUS_C = 2'd0/1/2
  - state enum {IDLE, ARB, GRANT}
  - grant struct {bus[1:0], chan[3:0]}
- **Sub-module `c432_prio_sel`:** purely combinational. Inputs are the three masked pending vectors; outputs are `found`, `bus` and `chan`, using fixed priority bus-then-index.
- **Top module:** pending registers, mask register, FSM and timeout counter only.

## Test plan
- Reset, then `req_b` = 9'h010 pulsed for one cycle in cycle 0 → `irq_valid` high in cycle 3 with bus = 1, chan = 4. Ack in cycle 3 → `irq_valid` = 0 in cycle 4 and `pend_any` = 0.
- `req_c` = 9'h001 and `req_a` = 9'h100 held together, acked immediately → first grant is bus 0, chan 8; second grant is bus 2, chan 0, exactly 3 cycles later.
- `en_wdata` = 9'h1FB with `en_we`, then `req_a` = 9'h004 → no grant and `pend_any` = 0. Rewrite the mask to 9'h1FF → grant bus 0, chan 2 three cycles after the write.
- Grant issued, no ack for 15 cycles → `irq_valid` high for exactly 15 cycles, then `timeout_err` pulses for 1 cycle and the pending bit is cleared. Repeat with ack in the 15th cycle → no `timeout_err`.
- Same-cycle ack and a new request on the granted bit (bus 0, chan 3) → pending bit stays set and is re-granted 3 cycles later.
- RST asserted for 1 cycle mid-GRANT → next cycle `irq_valid` = 0, `en_q` = 9'h1FF, all pending bits 0, no `timeout_err`.
